mac_operand_sequencer: RTL and testbench

- Initiator side of the MAC unit interface (mac_unit_with_fsm): buffers 2-bit operand pairs in a small FIFO.
- Drives the MAC's a/b/run/reset inputs in fixed-length accumulation groups, then captures each 8-bit accumulated result.
- Sits between the operand source and the MAC/FSM block, replacing hand-driven stimulus.

---
 rtl/mac_operand_sequencer.sv | 158 +++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the MAC unit: buffers 2-bit operand pairs and feeds
// them to the MAC in fixed-length accumulation groups, capturing each result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | MAC held (run=0, reset=0); waiting for start
// WAIT_DATA | job active, waiting until a full group is buffered
// CLEAR     | one cycle of mac_reset to zero the accumulator
// RUN       | GROUP cycles, one operand pair popped per cycle
// DRAIN     | MAC_LATENCY idle cycles so mac_out settles
// CAPTURE   | sample mac_out, then next group or finish
module mac_operand_sequencer #(
  parameter int DEPTH       = 8,
  parameter int GROUP       = 4,
  parameter int MAC_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [1:0] wr_a,
  input  logic [1:0] wr_b,
  output logic       wr_ready,
  input  logic       start,
  input  logic [3:0] num_groups,
  output logic       busy,
  output logic       done,
  output logic [1:0] mac_a,
  output logic [1:0] mac_b,
  output logic       mac_run,
  output logic       mac_reset,
  output logic [3:0] mac_zero_input,
  input  logic [7:0] mac_out,
  output logic [7:0] result,
  output logic       result_valid
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int TMAX = (GROUP > MAC_LATENCY) ? GROUP : MAC_LATENCY;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] RUN_LOAD   = TW'(GROUP - 1);
  localparam logic [TW-1:0] DRAIN_LOAD = TW'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_CLEAR, S_RUN, S_DRAIN, S_CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic [TW-1:0] tmr;
  logic [3:0]    remaining;

  assign push           = wr_valid && wr_ready;
  assign pop            = (state == S_RUN);
  assign mac_zero_input = 4'd0;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {wr_a, wr_b};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      wr_ready <= (count_nxt < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start && num_groups != 4'd0) state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (count >= CW'(GROUP)) state_nxt = S_CLEAR;
      S_CLEAR:     state_nxt = S_RUN;
      S_RUN:       if (tmr == '0) state_nxt = (MAC_LATENCY == 0) ? S_CAPTURE : S_DRAIN;
      S_DRAIN:     if (tmr == '0) state_nxt = S_CAPTURE;
      S_CAPTURE:   state_nxt = (remaining == 4'd1) ? S_IDLE : S_WAIT_DATA;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // MAC-facing outputs trail the state by one cycle so every port is a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= 8'd0;
      result_valid <= 1'b0;
      mac_a        <= 2'd0;
      mac_b        <= 2'd0;
      mac_run      <= 1'b0;
      mac_reset    <= 1'b1;
      remaining    <= 4'd0;
      tmr          <= '0;
    end else begin
      done         <= 1'b0;
      result_valid <= 1'b0;
      mac_run      <= (state == S_RUN);
      mac_reset    <= (state == S_CLEAR);
      if (pop)
        {mac_a, mac_b} <= fifo_mem[rd_ptr];
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_groups != 4'd0) begin
              remaining <= num_groups;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_CLEAR: tmr <= RUN_LOAD;
        S_RUN:   tmr <= (tmr == '0) ? DRAIN_LOAD : tmr - TW'(1);
        S_DRAIN: if (tmr != '0) tmr <= tmr - TW'(1);
        S_CAPTURE: begin
          result       <= mac_out;
          result_valid <= 1'b1;
          remaining    <= remaining - 4'd1;
          if (remaining == 4'd1) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer: a behavioural MAC plus a
// queue-based reference model predict every MAC operand and group result.
module tb_mac_operand_sequencer;
  localparam int DEPTH       = 8;
  localparam int GROUP       = 4;
  localparam int MAC_LATENCY = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_a = 2'd0, wr_b = 2'd0;
  logic       wr_ready;
  logic       start = 1'b0;
  logic [3:0] num_groups = 4'd0;
  logic       busy, done;
  logic [1:0] mac_a, mac_b;
  logic       mac_run, mac_reset;
  logic [3:0] mac_zero_input;
  logic [7:0] mac_out, result;
  logic       result_valid;

  mac_operand_sequencer #(.DEPTH(DEPTH), .GROUP(GROUP), .MAC_LATENCY(MAC_LATENCY)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_a(wr_a), .wr_b(wr_b),
    .wr_ready(wr_ready), .start(start), .num_groups(num_groups), .busy(busy),
    .done(done), .mac_a(mac_a), .mac_b(mac_b), .mac_run(mac_run),
    .mac_reset(mac_reset), .mac_zero_input(mac_zero_input), .mac_out(mac_out),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: clear on reset, accumulate a*b on run.
  logic [7:0] acc;
  always @(posedge clk) begin
    if (mac_reset) acc <= 8'd0;
    else if (mac_run) acc <= acc + 8'(mac_a) * 8'(mac_b);
  end
  assign mac_out = acc;

  int errors = 0, checks = 0;
  logic [3:0] pend[$];
  logic [3:0] pair_q[$];
  logic [7:0] exp_q[$];
  int pending_done = 0;
  int tot_pushed = 0, tot_results = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      tot_results++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0d expected none", result);
      end else begin
        chk("result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
    if (mac_run === 1'b1) begin
      if (pair_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mac_run: got a=%0d b=%0d expected no run", mac_a, mac_b);
      end else begin
        chk("mac_pair", 32'({mac_a, mac_b}), 32'(pair_q.pop_front()));
      end
    end
    if (done === 1'b1) begin
      if (pending_done == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        pending_done--;
        chk("results_before_done", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic sched(input logic [1:0] a, input logic [1:0] b);
    pend.push_back({a, b});
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b);
    int n = 0;
    while (tot_pushed - GROUP * tot_results >= DEPTH && n < 500) begin
      tick();
      n++;
    end
    chk("push_wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_a = a; wr_b = b;
    pair_q.push_back({a, b});
    tot_pushed++;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic push_sched(input logic [1:0] a, input logic [1:0] b);
    sched(a, b);
    push(a, b);
  endtask

  // Reference: each group's result is the sum of products of the next GROUP pairs.
  task automatic claim(input int g);
    for (int gi = 0; gi < g; gi++) begin
      int sum = 0;
      for (int k = 0; k < GROUP; k++) begin
        logic [3:0] p;
        p = pend.pop_front();
        sum += int'(p[3:2]) * int'(p[1:0]);
      end
      exp_q.push_back(8'(sum));
    end
    pending_done++;
  endtask

  task automatic do_start(input logic [3:0] g);
    start = 1'b1; num_groups = g;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending_done != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("wait_idle_pending", 32'(pending_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] np[$];
    logic [3:0] v;
    // Reset
    tick();
    chk("rst_outputs", 32'({busy, done, result, result_valid, mac_a, mac_b, mac_run, mac_zero_input}), 32'd0);
    chk("rst_mac_reset", 32'(mac_reset), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("mac_reset_release", 32'(mac_reset), 32'd0);

    // Exact cycle timing of one group with data already buffered
    for (int i = 0; i < 4; i++) push_sched(2'd2, 2'd2);
    claim(1);
    tick();
    start = 1'b1; num_groups = 4'd1;
    for (int c = 0; c < 10; c++) begin
      logic [4:0] e;
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
      e[4] = (c < 3 + GROUP + MAC_LATENCY);
      e[3] = (c == 2);
      e[2] = (c >= 3 && c <= 2 + GROUP);
      e[1] = (c == 3 + GROUP + MAC_LATENCY);
      e[0] = (c == 3 + GROUP + MAC_LATENCY);
      chk($sformatf("timing_c%0d", c), 32'({busy, mac_reset, mac_run, result_valid, done}), 32'(e));
    end
    wait_idle();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("result_hold_16", 32'(result), 32'd16);

    // Two groups back to back
    push_sched(2'd2, 2'd2); push_sched(2'd3, 2'd3); push_sched(2'd1, 2'd1); push_sched(2'd1, 2'd1);
    for (int i = 0; i < 4; i++) push_sched(2'd1, 2'd1);
    claim(2);
    do_start(4'd2);
    wait_idle();

    // Start with only half a group buffered
    np.delete();
    for (int i = 0; i < 4; i++) begin
      v = 4'($urandom_range(0, 15));
      np.push_back(v);
      sched(v[3:2], v[1:0]);
    end
    claim(1);
    push(np[0][3:2], np[0][1:0]);
    push(np[1][3:2], np[1][1:0]);
    do_start(4'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wait_data_no_run", 32'({busy, mac_run}), 32'b10);
    end
    push(np[2][3:2], np[2][1:0]);
    push(np[3][3:2], np[3][1:0]);
    wait_idle();

    // Fill to DEPTH, then a dropped push
    push_sched(2'd1, 2'd2);
    for (int i = 1; i < DEPTH; i++) push_sched(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_a = 2'd3; wr_b = 2'd3;
    tick();
    wr_valid = 1'b0;
    chk("full_still_not_ready", 32'(wr_ready), 32'd0);
    claim(2);
    do_start(4'd2);
    wait_idle();

    // Reset in the middle of a group
    for (int i = 0; i < 4; i++) push_sched(2'd3, 2'd3);
    claim(1);
    do_start(4'd1);
    for (int i = 0; i < 20 && mac_run !== 1'b1; i++) tick();
    chk("saw_run_before_abort", 32'(mac_run), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    pend.delete(); pair_q.delete(); exp_q.delete();
    pending_done = 0; tot_pushed = 0; tot_results = 0;
    tick();
    chk("abort_outputs", 32'({busy, done, result_valid, mac_run}), 32'd0);
    chk("abort_mac_reset", 32'(mac_reset), 32'd1);
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 4; i++) push_sched(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    claim(1);
    do_start(4'd1);
    wait_idle();

    // num_groups == 0
    pending_done++;
    do_start(4'd0);
    chk("zero_groups_done", 32'({done, busy}), 32'b10);
    for (int i = 0; i < 6; i++) tick();

    // start while busy is ignored
    for (int i = 0; i < 4; i++) push_sched(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    claim(1);
    do_start(4'd1);
    tick();
    do_start(4'd5);
    wait_idle();
    for (int i = 0; i < 20; i++) tick();
    chk("busy_ignore_idle", 32'(busy), 32'd0);

    // Randomized jobs with pushes overlapping the runs
    for (int t = 0; t < 12; t++) begin
      int g, extra, need, room, p0, idx;
      g = $urandom_range(1, 3);
      extra = $urandom_range(0, 2);
      need = g * GROUP + extra - pend.size();
      np.delete();
      for (int i = 0; i < need; i++) begin
        v = 4'($urandom_range(0, 15));
        np.push_back(v);
        sched(v[3:2], v[1:0]);
      end
      claim(g);
      room = DEPTH - (tot_pushed - GROUP * tot_results);
      p0 = $urandom_range(0, (need < room) ? need : room);
      idx = 0;
      for (int i = 0; i < p0; i++) begin
        push(np[idx][3:2], np[idx][1:0]);
        idx++;
      end
      do_start(4'(g));
      while (idx < need) begin
        int gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) tick();
        push(np[idx][3:2], np[idx][1:0]);
        idx++;
      end
      wait_idle();
    end

    for (int i = 0; i < 10; i++) tick();
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
